// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the byte-wide memory bus
// seen by dmem_port_arbiter.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 5
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              ack0;
  logic              ack1;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // requesters plus the memory array
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  // the arbiter
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter that serialises 32-bit word transfers onto a byte-wide
// data memory as four big-endian beats.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for req0/req1; picks a winner and latches its request
// S_BEAT | four memory beats (beat 0..3), read bytes captured one late
// S_LAST | bus quiet; last read byte lands, owner's rdata updated
// S_ACK  | one-cycle ack to the owning port
module dmem_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter bit RR_EN  = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_LAST, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic              load;
  logic              grant_id;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic              id_q;
  logic              last_q;
  logic [23:0]       shift_q;
  logic [31:0]       rdata0_q;
  logic [31:0]       rdata1_q;
  logic              in_beat;
  logic [7:0]        beat_byte;

  // winner selection; on contention round-robin favours the port not granted last
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_id = RR_EN ? ~last_q : 1'b0;
    end else begin
      grant_id = bus.req1;
    end
  end

  // state and beat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          load    = 1'b1;
          beat_d  = 2'd0;
          state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = S_LAST;
      end
      S_LAST:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // latch the granted request; later changes on the requester side are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else if (load) begin
      we_q    <= grant_id ? bus.we1    : bus.we0;
      base_q  <= grant_id ? bus.addr1  : bus.addr0;
      wdata_q <= grant_id ? bus.wdata1 : bus.wdata0;
      id_q    <= grant_id;
      last_q  <= grant_id;
    end
  end

  // read assembly: memory returns each byte one cycle after its beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (!we_q) begin
      if (state_q == S_BEAT && beat_q != 2'd0) begin
        shift_q <= {shift_q[15:0], bus.mem_rdata};
      end
      if (state_q == S_LAST) begin
        if (id_q) rdata1_q <= {shift_q, bus.mem_rdata};
        else      rdata0_q <= {shift_q, bus.mem_rdata};
      end
    end
  end

  // big-endian byte select for the current beat
  always_comb begin
    beat_byte = 8'h00;
    case (beat_q)
      2'd0: beat_byte = wdata_q[31:24];
      2'd1: beat_byte = wdata_q[23:16];
      2'd2: beat_byte = wdata_q[15:8];
      2'd3: beat_byte = wdata_q[7:0];
      default: beat_byte = 8'h00;
    endcase
  end

  assign in_beat       = (state_q == S_BEAT);
  assign bus.mem_en    = in_beat;
  assign bus.mem_we    = in_beat & we_q;
  assign bus.mem_addr  = in_beat ? base_q + ADDR_W'(beat_q) : '0;
  assign bus.mem_wdata = in_beat ? beat_byte : 8'h00;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ack0      = (state_q == S_ACK) & ~id_q;
  assign bus.ack1      = (state_q == S_ACK) &  id_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: instance A (round-robin) with a byte memory model,
// instance B (fixed priority) driven by the same requester stimulus.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        mem_clr;
  logic [7:0]  mem [32];
  logic [7:0]  mem_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  dmem_port_arbiter_if #(.ADDR_W(5)) bus_a ();
  dmem_port_arbiter_if #(.ADDR_W(5)) bus_b ();

  dmem_port_arbiter #(.ADDR_W(5), .RR_EN(1'b1)) u_dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  dmem_port_arbiter #(.ADDR_W(5), .RR_EN(1'b0)) u_dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  assign bus_a.req0 = req0;     assign bus_b.req0 = req0;
  assign bus_a.req1 = req1;     assign bus_b.req1 = req1;
  assign bus_a.we0 = we0;       assign bus_b.we0 = we0;
  assign bus_a.we1 = we1;       assign bus_b.we1 = we1;
  assign bus_a.addr0 = addr0;   assign bus_b.addr0 = addr0;
  assign bus_a.addr1 = addr1;   assign bus_b.addr1 = addr1;
  assign bus_a.wdata0 = wdata0; assign bus_b.wdata0 = wdata0;
  assign bus_a.wdata1 = wdata1; assign bus_b.wdata1 = wdata1;
  assign bus_a.mem_rdata = mem_rd;
  assign bus_b.mem_rdata = 8'h00;

  // byte memory model: synchronous write, read data one cycle after the beat
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem_rd <= 8'h00;
    end else if (bus_a.mem_en) begin
      if (bus_a.mem_we) mem[bus_a.mem_addr] <= bus_a.mem_wdata;
      else              mem_rd <= mem[bus_a.mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one transfer from IDLE; pulse=1 drops req and scrambles the request after the grant
  task automatic xfer(input bit port, input bit we, input logic [4:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit pulse);
    logic [4:0] ea;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (pulse && k == 1) begin
        req0 = 1'b0; req1 = 1'b0; we0 = ~we; we1 = ~we;
        addr0 = addr + 5'd8; addr1 = addr + 5'd8; wdata0 = ~wd; wdata1 = ~wd;
      end
      if (k <= 4) begin
        ea = addr + 5'(k - 1);
        check_val($sformatf("beat%0d_en", k), 32'(bus_a.mem_en), 32'd1);
        check_val($sformatf("beat%0d_we", k), 32'(bus_a.mem_we), 32'(we));
        check_val($sformatf("beat%0d_addr", k), 32'(bus_a.mem_addr), 32'(ea));
        if (we) check_val($sformatf("beat%0d_wdata", k), 32'(bus_a.mem_wdata), 32'(8'(wd >> (32 - 8 * k))));
      end else if (k == 5) begin
        check_val("last_en", 32'(bus_a.mem_en), 32'd0);
        check_val("last_busy", 32'(bus_a.busy), 32'd1);
        check_val("last_acks", 32'({bus_a.ack1, bus_a.ack0}), 32'd0);
      end else begin
        check_val("ack_acks", 32'({bus_a.ack1, bus_a.ack0}), port ? 32'd2 : 32'd1);
        check_val("ack_busy", 32'(bus_a.busy), 32'd1);
        check_val("ack_en", 32'(bus_a.mem_en), 32'd0);
        if (!we) check_val("ack_rdata", port ? bus_a.rdata1 : bus_a.rdata0, exp_rd);
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    @(posedge clk); #1;
    check_val("idle_busy", 32'(bus_a.busy), 32'd0);
    check_val("idle_acks", 32'({bus_a.ack1, bus_a.ack0}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_acks", 32'({bus_a.ack1, bus_a.ack0}), 32'd0);
    check_val("rst_rdata0", bus_a.rdata0, 32'd0);
    check_val("rst_rdata1", bus_a.rdata1, 32'd0);
    check_val("rst_ctl", 32'({bus_a.busy, bus_a.mem_en, bus_a.mem_we}), 32'd0);
    check_val("rst_addr", 32'(bus_a.mem_addr), 32'd0);
    check_val("rst_wdata", 32'(bus_a.mem_wdata), 32'd0);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(posedge clk); #1;

    // single write
    xfer(1'b0, 1'b1, 5'd4, 32'hA1B2C3D4, 32'h0, 1'b0);
    check_val("wr4_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hA1B2C3D4);

    // preload by write, then read on port 1
    xfer(1'b1, 1'b1, 5'd8, 32'h11223344, 32'h0, 1'b0);
    xfer(1'b1, 1'b0, 5'd8, 32'h0, 32'h11223344, 1'b0);
    check_val("rd8_rdata0_kept", bus_a.rdata0, 32'd0);

    // wrap-around write and read-back
    xfer(1'b0, 1'b1, 5'd30, 32'hDEADBEEF, 32'h0, 1'b0);
    check_val("wrap_mem", {mem[30], mem[31], mem[0], mem[1]}, 32'hDEADBEEF);
    xfer(1'b0, 1'b0, 5'd30, 32'h0, 32'hDEADBEEF, 1'b0);
    check_val("wrap_rdata1_kept", bus_a.rdata1, 32'h11223344);

    // request pulsed for one IDLE cycle; later input changes ignored
    xfer(1'b0, 1'b1, 5'd16, 32'h01020304, 32'h0, 1'b1);
    check_val("pulse_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'h01020304);
    check_val("pulse_mem_alias", {mem[24], mem[25], mem[26], mem[27]}, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check_val("pulse_no_retx", 32'(bus_a.busy), 32'd0);
    end

    // reset during beat 2 of a port-1 write
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd20; wdata1 = 32'h55667788;
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_beat2_addr", 32'(bus_a.mem_addr), 32'd22);
    rst_n = 1'b0; req1 = 1'b0;
    #1;
    check_val("mid_rst_ctl", 32'({bus_a.busy, bus_a.mem_en, bus_a.mem_we, bus_a.ack1, bus_a.ack0}), 32'd0);
    check_val("mid_rst_rdata0", bus_a.rdata0, 32'd0);
    check_val("mid_rst_rdata1", bus_a.rdata1, 32'd0);
    check_val("mid_rst_bus", 32'({bus_a.mem_addr, bus_a.mem_wdata}), 32'd0);
    @(posedge clk); #1;
    check_val("mid_partial", 32'({mem[20], mem[21], mem[22]}), 32'h556600);

    // contention right after reset release: port 0 first, then alternate
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd8;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd4;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); #1;
      if (k % 7 == 6) begin
        check_val($sformatf("rr_acks_c%0d", k), 32'({bus_a.ack1, bus_a.ack0}),
                  ((k / 7) % 2 == 0) ? 32'd1 : 32'd2);
        check_val($sformatf("fp_acks_c%0d", k), 32'({bus_b.ack1, bus_b.ack0}), 32'd1);
        if ((k / 7) % 2 == 0) check_val($sformatf("rr_rdata0_c%0d", k), bus_a.rdata0, 32'h11223344);
        else                  check_val($sformatf("rr_rdata1_c%0d", k), bus_a.rdata1, 32'hA1B2C3D4);
      end else begin
        check_val($sformatf("rr_noack_c%0d", k), 32'({bus_a.ack1, bus_a.ack0}), 32'd0);
      end
      if (k == 27) begin req0 = 1'b0; req1 = 1'b0; end
    end
    @(posedge clk); #1;
    check_val("end_idle", 32'(bus_a.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
